mine_reveal_engine: RTL and testbench
=====================================

Name: mine_reveal_engine

Overview:
- Consumer side of the bomb placement block: latches a `bomb_grid` snapshot and runs one game of mines on it.
- Accepts player reveal requests through a valid/ready handshake.
- For each reveal, reports hit/safe and the neighbouring-bomb count, found by a sequential 8-neighbour scan.
- Tracks the revealed-cell mask and the safe cells remaining, and declares win or loss.
- Sits between `multi_bomb_placement` and the display/UI logic.

Parameters:
- GRID_W, 4, grid side length; cell index = row*GRID_W + col (row = idx/GRID_W, col = idx%GRID_W).
- CELLS, GRID_W*GRID_W, derived cell count; not to be overridden.
- IW, $clog2(GRID_W), row/column index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- bomb_grid  in  CELLS  bomb map from the placement block; bit i = 1 means a bomb in cell i.
- grid_load  in  1  single-cycle pulse; latch bomb_grid and start a new game.
- reveal_valid  in  1  reveal request valid.
- reveal_ready  out  1  engine can accept a reveal.
- reveal_row  in  IW  requested row.
- reveal_col  in  IW  requested column.
- result_valid  out  1  single-cycle pulse; result fields are valid.
- result_hit  out  1  revealed cell held a bomb.
- result_repeat  out  1  cell was already revealed.
- neighbour_count  out  4  bombs among the in-bounds 8-neighbours (0..8).
- revealed_mask  out  CELLS  cells revealed so far.
- safe_left  out  $clog2(CELLS)+1  unrevealed safe cells.
- game_won  out  1  level signal; game won.
- game_lost  out  1  level signal; game lost.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including revealed_mask, safe_left and the latched grid.
- States: IDLE, PLAY, SCAN, WON, LOST.
- grid_load in any state (highest priority):
  - latch grid_q <= bomb_grid; revealed_mask <= 0; safe_left <= CELLS - popcount(bomb_grid).
  - clear game_won and game_lost; go to PLAY.
  - any scan in progress is aborted with no result_valid.
- In PLAY:
  - if safe_left == 0, go to WON next cycle.
  - otherwise reveal_ready=1.
- reveal_ready is 0 in IDLE, SCAN, WON and LOST.
- A transfer occurs when reveal_valid && reveal_ready. On transfer (cycle 0):
  - capture the target index; go to SCAN.
- SCAN:
  - takes exactly 8 cycles.
  - one neighbour offset per cycle, in order (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1).
  - out-of-bounds offsets (row/col <0 or >=GRID_W) contribute 0; there is no wrap-around.
  - accumulator width is 4 bits, so there is no overflow.
- Cycle 9 after transfer: result_valid=1 for one cycle.
  - neighbour_count holds the scan total until the next result.
  - result_hit = grid_q[target]; result_repeat = revealed_mask[target] before this reveal.
- Update rules, applied with result_valid:
  - repeat: no change to mask, safe_left or state; return to PLAY.
  - hit (not repeat): set the mask bit; go to LOST.
  - safe (not repeat): set the mask bit; safe_left -= 1; if it becomes 0 go to WON, else go to PLAY.
- WON/LOST:
  - game_won/game_lost asserted and held until grid_load or reset.
  - reveal requests are ignored.
- bomb_grid changes outside a grid_load have no effect.

Optional Feature:
- Macro: FIRST_SAFE_EN.
- Defined: on the first non-repeat reveal of a game, if grid_q[target]=1:
  - the bomb is relocated in the transfer cycle to the lowest-index cell with grid_q=0 and index != target.
  - the target is cleared; safe_left is unchanged; the scan uses the relocated grid.
  - result_hit=0.
  - if no such cell exists, the reveal is treated as a normal hit.
- Undefined: there is no relocation; a first-reveal bomb causes an immediate loss.

Test Plan:
- Reset, then grid_load with bomb_grid=16'h0009 -> state PLAY, safe_left=14, reveal_ready=1, mask=0.
- Neighbour count: grid 16'h0009, reveal (1,1) -> result_valid exactly 9 cycles after transfer, result_hit=0, neighbour_count=1, safe_left=13, mask=16'h0020.
- Corner, no wrap: grid 16'h0032, reveal (0,0) -> neighbour_count=3.
- Corner, no wrap: grid 16'h0032, reveal (3,3) -> neighbour_count=0.
- Repeat: reveal (1,1) again -> result_repeat=1, safe_left unchanged at 13, state PLAY.
- Loss: grid 16'h0009, reveal (0,0) -> result_hit=1, game_lost=1, reveal_ready=0.
  - With FIRST_SAFE_EN and (0,0) as the first reveal: result_hit=0, bomb moved to cell 1, neighbour_count=1.
- Win and abort:
  - grid 16'h8000, reveal cells 0..14 -> safe_left counts 14..0, game_won=1 after the 15th result.
  - grid_load issued 3 cycles into a SCAN -> no result_valid, mask=0.
  - reset low mid-SCAN -> all outputs 0 immediately.

Source files
------------

// File: rtl/mine_reveal_engine_if.sv
// ---------------------------------------------------------------------------
// mine_reveal_engine_if
//   Reveal request/result channel between the player/UI side and the
//   mine_reveal_engine.
//
//   reveal_valid / reveal_ready  : request handshake, transfer on both high
//   reveal_row / reveal_col      : requested cell coordinates
//   result_valid                 : single-cycle pulse, result fields valid
//   result_hit / result_repeat   : bomb hit / cell already revealed
//   neighbour_count              : bombs among the in-bounds 8 neighbours
//
//   master : request issuer (player/UI or testbench)
//   slave  : the reveal engine
// ---------------------------------------------------------------------------
interface mine_reveal_engine_if #(
    parameter int GRID_W = 4
) ();
    localparam int IW = $clog2(GRID_W);

    logic          reveal_valid;
    logic          reveal_ready;
    logic [IW-1:0] reveal_row;
    logic [IW-1:0] reveal_col;
    logic          result_valid;
    logic          result_hit;
    logic          result_repeat;
    logic [3:0]    neighbour_count;

    modport master (
        output reveal_valid, reveal_row, reveal_col,
        input  reveal_ready, result_valid, result_hit, result_repeat, neighbour_count
    );

    modport slave (
        input  reveal_valid, reveal_row, reveal_col,
        output reveal_ready, result_valid, result_hit, result_repeat, neighbour_count
    );
endinterface

// File: rtl/mine_reveal_engine.sv
// ---------------------------------------------------------------------------
// mine_reveal_engine
//   Latches a bomb map from the placement block and plays one game of mines
//   on it. Each accepted reveal starts an 8-cycle neighbour scan (one offset
//   per cycle); the result is pulsed on the cycle after the scan and the
//   revealed mask / safe-cell count / win-loss status are updated with it.
//
//   Ports:
//     clk            system clock, rising edge
//     reset          asynchronous, active-low reset
//     bomb_grid      bomb map, bit i = bomb in cell i (i = row*GRID_W + col)
//     grid_load      one-cycle pulse: latch bomb_grid, start a new game
//     rv             reveal request / result channel (slave side)
//     revealed_mask  cells revealed so far
//     safe_left      unrevealed safe cells
//     game_won       level, game won
//     game_lost      level, game lost
//
//   Optional feature (macro FIRST_SAFE_EN): a bomb under the first reveal of
//   a game is moved to the lowest-index free cell before the scan, so the
//   first reveal can never lose.
// ---------------------------------------------------------------------------
module mine_reveal_engine #(
    parameter int GRID_W = 4,
    parameter int CELLS  = GRID_W * GRID_W,
    parameter int IW     = $clog2(GRID_W)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CELLS-1:0]           bomb_grid,
    input  logic                       grid_load,
    mine_reveal_engine_if.slave        rv,
    output logic [CELLS-1:0]           revealed_mask,
    output logic [$clog2(CELLS):0]     safe_left,
    output logic                       game_won,
    output logic                       game_lost
);
    localparam int CW  = $clog2(CELLS);
    localparam int SLW = CW + 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PLAY = 3'd1;
    localparam logic [2:0] SCAN = 3'd2;
    localparam logic [2:0] WON  = 3'd3;
    localparam logic [2:0] LOST = 3'd4;

    logic [2:0]       state;
    logic [CELLS-1:0] grid_q;
    logic [IW-1:0]    tgt_row;
    logic [IW-1:0]    tgt_col;
    logic [2:0]       scan_idx;
    logic [3:0]       acc;
    logic             result_valid_q;
    logic             result_hit_q;
    logic             result_repeat_q;
    logic [3:0]       count_q;

    function automatic logic [SLW-1:0] popcount(input logic [CELLS-1:0] v);
        logic [SLW-1:0] n;
        n = '0;
        for (int i = 0; i < CELLS; i++) begin
            n = n + SLW'(v[i]);
        end
        return n;
    endfunction

    // Neighbour offsets in scan order, as 2-bit two's complement (-1/0/+1):
    // (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1)
    function automatic logic signed [1:0] row_off(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd2: return 2'sb11;
            3'd3, 3'd4:       return 2'sb00;
            default:          return 2'sb01;
        endcase
    endfunction

    function automatic logic signed [1:0] col_off(input logic [2:0] k);
        case (k)
            3'd0, 3'd3, 3'd5: return 2'sb11;
            3'd1, 3'd6:       return 2'sb00;
            default:          return 2'sb01;
        endcase
    endfunction

    logic signed [1:0] dr;
    logic signed [1:0] dc;
    logic [IW+1:0]     nb_row;
    logic [IW+1:0]     nb_col;
    logic              nb_in;
    logic [CW-1:0]     nb_idx;
    logic              nb_bomb;
    logic [3:0]        acc_next;
    logic [CW-1:0]     tgt_idx;

    // Neighbour coordinates are formed with two guard bits: an underflow
    // sets the top bit, an overflow compares >= GRID_W, so no wrap-around.
    always_comb begin
        dr       = row_off(scan_idx);
        dc       = col_off(scan_idx);
        nb_row   = {2'b00, tgt_row} + {{IW{dr[1]}}, dr};
        nb_col   = {2'b00, tgt_col} + {{IW{dc[1]}}, dc};
        nb_in    = !nb_row[IW+1] && (nb_row < (IW+2)'(GRID_W)) &&
                   !nb_col[IW+1] && (nb_col < (IW+2)'(GRID_W));
        nb_idx   = CW'(nb_row[IW-1:0] * GRID_W) + CW'(nb_col[IW-1:0]);
        nb_bomb  = nb_in && grid_q[nb_idx];
        acc_next = acc + {3'b000, nb_bomb};
        tgt_idx  = CW'(tgt_row * GRID_W) + CW'(tgt_col);
    end

`ifdef FIRST_SAFE_EN
    logic [CW-1:0]    req_idx;
    logic [CW-1:0]    reloc_idx;
    logic             reloc_found;
    logic [CELLS-1:0] grid_reloc;

    // An empty revealed mask marks the first reveal of a game: a repeat is
    // impossible before anything has been revealed.
    always_comb begin
        req_idx     = CW'(rv.reveal_row * GRID_W) + CW'(rv.reveal_col);
        reloc_found = 1'b0;
        reloc_idx   = '0;
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (!grid_q[i] && (CW'(i) != req_idx)) begin
                reloc_found = 1'b1;
                reloc_idx   = CW'(i);
            end
        end
        grid_reloc = grid_q;
        if ((revealed_mask == '0) && grid_q[req_idx] && reloc_found) begin
            grid_reloc[req_idx]   = 1'b0;
            grid_reloc[reloc_idx] = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            grid_q          <= '0;
            revealed_mask   <= '0;
            safe_left       <= '0;
            tgt_row         <= '0;
            tgt_col         <= '0;
            scan_idx        <= '0;
            acc             <= '0;
            result_valid_q  <= 1'b0;
            result_hit_q    <= 1'b0;
            result_repeat_q <= 1'b0;
            count_q         <= '0;
        end else begin
            result_valid_q <= 1'b0;
            if (grid_load) begin
                // Also aborts any scan in flight; no result is produced.
                grid_q        <= bomb_grid;
                revealed_mask <= '0;
                safe_left     <= SLW'(CELLS) - popcount(bomb_grid);
                state         <= PLAY;
            end else begin
                case (state)
                    PLAY: begin
                        if (safe_left == '0) begin
                            state <= WON;
                        end else if (rv.reveal_valid) begin
                            tgt_row  <= rv.reveal_row;
                            tgt_col  <= rv.reveal_col;
                            scan_idx <= '0;
                            acc      <= '0;
                            state    <= SCAN;
`ifdef FIRST_SAFE_EN
                            grid_q   <= grid_reloc;
`endif
                        end
                    end
                    SCAN: begin
                        acc      <= acc_next;
                        scan_idx <= scan_idx + 3'd1;
                        if (scan_idx == 3'd7) begin
                            result_valid_q  <= 1'b1;
                            count_q         <= acc_next;
                            result_hit_q    <= grid_q[tgt_idx];
                            result_repeat_q <= revealed_mask[tgt_idx];
                            if (revealed_mask[tgt_idx]) begin
                                state <= PLAY;
                            end else begin
                                revealed_mask[tgt_idx] <= 1'b1;
                                if (grid_q[tgt_idx]) begin
                                    state <= LOST;
                                end else begin
                                    safe_left <= safe_left - SLW'(1);
                                    state     <= (safe_left == SLW'(1)) ? WON : PLAY;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rv.reveal_ready    = (state == PLAY) && (safe_left != '0);
    assign rv.result_valid    = result_valid_q;
    assign rv.result_hit      = result_hit_q;
    assign rv.result_repeat   = result_repeat_q;
    assign rv.neighbour_count = count_q;
    assign game_won           = (state == WON);
    assign game_lost          = (state == LOST);
endmodule

// File: tb/tb_mine_reveal_engine.sv
module tb_mine_reveal_engine;
    localparam int G = 4;
    localparam int N = G * G;

    logic        clk;
    logic        reset;
    logic [15:0] bomb_grid;
    logic        grid_load;
    logic [15:0] revealed_mask;
    logic [4:0]  safe_left;
    logic        game_won;
    logic        game_lost;

    mine_reveal_engine_if #(.GRID_W(G)) rv ();

    mine_reveal_engine #(.GRID_W(G)) dut (
        .clk           (clk),
        .reset         (reset),
        .bomb_grid     (bomb_grid),
        .grid_load     (grid_load),
        .rv            (rv),
        .revealed_mask (revealed_mask),
        .safe_left     (safe_left),
        .game_won      (game_won),
        .game_lost     (game_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [15:0] m_grid;
    logic [15:0] m_mask;
    int          m_safe;
    bit          m_won;
    bit          m_lost;

    function automatic int model_count(input logic [15:0] g, input int r, input int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr = r + dr;
                int cc = c + dc;
                if ((dr != 0 || dc != 0) && rr >= 0 && rr < G && cc >= 0 && cc < G)
                    n += int'(g[rr * G + cc]);
            end
        end
        return n;
    endfunction

    task automatic model_load(input logic [15:0] g);
        m_grid = g;
        m_mask = '0;
        m_safe = N - $countones(g);
        m_won  = (m_safe == 0);
        m_lost = 1'b0;
    endtask

    task automatic model_reveal(input int r, input int c, output logic hit, output logic rep, output int cnt);
        int idx = r * G + c;
        rep = m_mask[idx];
`ifdef FIRST_SAFE_EN
        if (!rep && m_mask == 16'h0 && m_grid[idx]) begin
            for (int j = 0; j < N; j++) begin
                if (!m_grid[j] && j != idx) begin
                    m_grid[j]   = 1'b1;
                    m_grid[idx] = 1'b0;
                    break;
                end
            end
        end
`endif
        hit = m_grid[idx];
        cnt = model_count(m_grid, r, c);
        if (!rep) begin
            m_mask[idx] = 1'b1;
            if (hit) m_lost = 1'b1;
            else begin
                m_safe--;
                if (m_safe == 0) m_won = 1'b1;
            end
        end
    endtask

    // ---------------- drivers (all driving/sampling #1 after posedge) ----------------
    task automatic load(input logic [15:0] g);
        bomb_grid = g;
        grid_load = 1'b1;
        @(posedge clk); #1;
        grid_load = 1'b0;
        bomb_grid = ~g;
        model_load(g);
    endtask

    task automatic do_reveal(input int r, input int c, output logic o_hit, output logic o_rep, output logic [3:0] o_cnt);
        logic e_hit, e_rep;
        int   e_cnt, w, lat;
        o_hit = 1'b0; o_rep = 1'b0; o_cnt = '0;
        w = 0;
        while (rv.reveal_ready !== 1'b1 && w < 6) begin
            @(posedge clk); #1; w++;
        end
        check("reveal_ready_before", rv.reveal_ready, 1);
        if (rv.reveal_ready !== 1'b1) return;
        model_reveal(r, c, e_hit, e_rep, e_cnt);
        rv.reveal_row   = 2'(r);
        rv.reveal_col   = 2'(c);
        rv.reveal_valid = 1'b1;
        @(posedge clk); #1;
        rv.reveal_valid = 1'b0;
        // transfer cycle is cycle 0; 8 scan cycles follow; result in cycle 9
        lat = 0;
        while (rv.result_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("result_latency", lat, 8);
        o_hit = rv.result_hit;
        o_rep = rv.result_repeat;
        o_cnt = rv.neighbour_count;
        check("result_hit", rv.result_hit, e_hit);
        check("result_repeat", rv.result_repeat, e_rep);
        check("neighbour_count", rv.neighbour_count, e_cnt);
        check("revealed_mask", revealed_mask, m_mask);
        check("safe_left", safe_left, m_safe);
        check("game_won", game_won, m_won);
        check("game_lost", game_lost, m_lost);
        check("reveal_ready_after", rv.reveal_ready, !(m_won || m_lost));
        @(posedge clk); #1;
        check("result_pulse_width", rv.result_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, rv.reveal_ready, 0);
        check({tag, "_rvalid"}, rv.result_valid, 0);
        check({tag, "_hit"}, rv.result_hit, 0);
        check({tag, "_rep"}, rv.result_repeat, 0);
        check({tag, "_count"}, rv.neighbour_count, 0);
        check({tag, "_mask"}, revealed_mask, 0);
        check({tag, "_safe"}, safe_left, 0);
        check({tag, "_won"}, game_won, 0);
        check({tag, "_lost"}, game_lost, 0);
    endtask

    typedef struct {
        logic [15:0] grid;
        int          row;
        int          col;
        logic        hit;
        logic [3:0]  cnt;
        int          safe;
        logic [15:0] mask;
        logic        won;
        logic        lost;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       h, p;
        logic [3:0] cn;
        int         seen;

        tbl[0] = '{16'h0009, 1, 1, 1'b0, 4'd1, 13, 16'h0020, 1'b0, 1'b0};
        tbl[1] = '{16'h0032, 0, 0, 1'b0, 4'd3, 12, 16'h0001, 1'b0, 1'b0};
        tbl[2] = '{16'h0032, 3, 3, 1'b0, 4'd0, 12, 16'h8000, 1'b0, 1'b0};
`ifdef FIRST_SAFE_EN
        tbl[3] = '{16'h0009, 0, 0, 1'b0, 4'd1, 13, 16'h0001, 1'b0, 1'b0};
`else
        tbl[3] = '{16'h0009, 0, 0, 1'b1, 4'd0, 14, 16'h0001, 1'b0, 1'b1};
`endif
        tbl[4] = '{16'h0000, 2, 1, 1'b0, 4'd0, 15, 16'h0200, 1'b0, 1'b0};
        tbl[5] = '{16'hFFFE, 0, 0, 1'b0, 4'd3, 0,  16'h0001, 1'b1, 1'b0};

        reset = 1'b0; bomb_grid = '0; grid_load = 1'b0;
        rv.reveal_valid = 1'b0; rv.reveal_row = '0; rv.reveal_col = '0;
        model_load(16'h0);
        repeat (2) @(posedge clk); #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", rv.reveal_ready, 0);

        // load: PLAY with 14 safe cells
        load(16'h0009);
        check("load_safe", safe_left, 14);
        check("load_ready", rv.reveal_ready, 1);
        check("load_mask", revealed_mask, 0);
        check("load_won", game_won, 0);

        // table-driven single reveals from a fresh game each
        for (int i = 0; i < 6; i++) begin
            load(tbl[i].grid);
            do_reveal(tbl[i].row, tbl[i].col, h, p, cn);
            check($sformatf("tbl%0d_hit", i), h, tbl[i].hit);
            check($sformatf("tbl%0d_cnt", i), cn, tbl[i].cnt);
            check($sformatf("tbl%0d_safe", i), safe_left, tbl[i].safe);
            check($sformatf("tbl%0d_mask", i), revealed_mask, tbl[i].mask);
            check($sformatf("tbl%0d_won", i), game_won, tbl[i].won);
            check($sformatf("tbl%0d_lost", i), game_lost, tbl[i].lost);
        end

`ifdef FIRST_SAFE_EN
        // relocated bomb sits in cell 1
        load(16'h0009);
        do_reveal(0, 0, h, p, cn);
        do_reveal(0, 1, h, p, cn);
        check("reloc_cell1_hit", h, 1);
`endif

        // repeat reveal leaves everything unchanged
        load(16'h0009);
        do_reveal(1, 1, h, p, cn);
        do_reveal(1, 1, h, p, cn);
        check("repeat_flag", p, 1);
        check("repeat_safe", safe_left, 13);
        check("repeat_ready", rv.reveal_ready, 1);

        // loss, then requests are ignored
        do_reveal(0, 0, h, p, cn);
        check("loss_hit", h, 1);
        check("loss_lost", game_lost, 1);
        rv.reveal_valid = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (rv.result_valid === 1'b1) seen++;
        end
        rv.reveal_valid = 1'b0;
        check("lost_ignores_reveal", seen, 0);
        check("lost_ready", rv.reveal_ready, 0);
        check("lost_held", game_lost, 1);

        // win: reveal cells 0..14 of a single-bomb grid
        load(16'h8000);
        for (int k = 0; k < 15; k++) begin
            do_reveal(k / G, k % G, h, p, cn);
            check($sformatf("win_safe_%0d", k), safe_left, 14 - k);
        end
        check("win_won", game_won, 1);
        check("win_ready", rv.reveal_ready, 0);

        // all bombs: PLAY for one cycle, then WON
        load(16'hFFFF);
        check("full_not_yet_won", game_won, 0);
        check("full_ready", rv.reveal_ready, 0);
        @(posedge clk); #1;
        check("full_won", game_won, 1);

        // grid_load three cycles into a scan aborts it
        load(16'h0009);
        rv.reveal_row = 2'd1; rv.reveal_col = 2'd1; rv.reveal_valid = 1'b1;
        @(posedge clk); #1;
        rv.reveal_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        load(16'h0009);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (rv.result_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        check("abort_no_result", seen, 0);
        check("abort_mask", revealed_mask, 0);
        check("abort_safe", safe_left, 14);
        check("abort_ready", rv.reveal_ready, 1);

        // asynchronous reset mid-scan
        do_reveal(2, 2, h, p, cn);
        rv.reveal_row = 2'd1; rv.reveal_col = 2'd1; rv.reveal_valid = 1'b1;
        @(posedge clk); #1;
        rv.reveal_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("midscan_reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle_ready", rv.reveal_ready, 0);
        check("post_reset_safe", safe_left, 0);

        // randomized games against the reference model
        for (int gi = 0; gi < 30; gi++) begin
            logic [15:0] g;
            g = 16'($urandom & $urandom);
            if (gi == 0) g = 16'hFFFF;
            load(g);
            if (m_safe == 0) begin
                @(posedge clk); #1;
                check("rand_full_won", game_won, 1);
                continue;
            end
            for (int k = 0; k < 10 && !m_won && !m_lost; k++) begin
                do_reveal($urandom_range(0, G - 1), $urandom_range(0, G - 1), h, p, cn);
            end
            if (m_won || m_lost) check("rand_over_ready", rv.reveal_ready, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
